// File: rtl/toll_output_unit.sv
// Toll-gate output stage: charges the hipass card, then opens the gate or raises the deny alarm.
// Define TOLL_TOPUP_EN to add a saturating balance top-up port.
module toll_output_unit #(
    parameter logic [7:0] FEE_C0       = 8'd10,
    parameter logic [7:0] FEE_C1       = 8'd20,
    parameter logic [7:0] FEE_C2       = 8'd35,
    parameter logic [7:0] FEE_C3       = 8'd50,
    parameter logic [7:0] INIT_BALANCE = 8'd100,
    parameter int         GATE_CYCLES  = 16,
    parameter int         ALARM_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       car,
    input  logic [3:0] hipass,
`ifdef TOLL_TOPUP_EN
    input  logic       topup_valid,
    input  logic [3:0] topup_id,
    input  logic [7:0] topup_amount,
    output logic       topup_ready,
`endif
    output logic       end_output,
    output logic       gate_open,
    output logic       deny_alarm,
    output logic [7:0] fee,
    output logic [7:0] balance_out,
    output logic       busy
);

    // state    | meaning
    // IDLE     | waiting for controller OUTPUT while armed
    // LOOKUP   | fetch fee and stored balance for the latched card
    // CHARGE   | grant (debit) or deny decision
    // HOLD     | gate open until car leaves or timer expires
    // ALARM    | deny alarm held for a fixed time
    // DONE     | one-cycle end_output pulse back to the controller

    localparam int TMAX = (GATE_CYCLES > ALARM_CYCLES) ? GATE_CYCLES : ALARM_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] GATE_LOAD  = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] ALARM_LOAD = TW'(ALARM_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHARGE,
        S_HOLD,
        S_ALARM,
        S_DONE
    } fsm_t;

    fsm_t          fsm;
    logic          armed;
    logic [3:0]    id;
    logic [7:0]    bal;
    logic [TW-1:0] timer;
    logic [7:0]    bal_table [16];
    logic          start;

    assign start = (fsm == S_IDLE) && (state == 2'b11) && armed;
    assign busy  = (fsm != S_IDLE);

    function automatic logic [7:0] class_fee(input logic [1:0] cls);
        case (cls)
            2'd0:    return FEE_C0;
            2'd1:    return FEE_C1;
            2'd2:    return FEE_C2;
            default: return FEE_C3;
        endcase
    endfunction

`ifdef TOLL_TOPUP_EN
    logic [8:0] topup_sum;
    // A starting transaction has priority; the requester keeps valid asserted.
    assign topup_ready = (fsm == S_IDLE) && !start;
    assign topup_sum   = {1'b0, bal_table[topup_id]} + {1'b0, topup_amount};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= S_IDLE;
            armed       <= 1'b1;
            id          <= '0;
            bal         <= '0;
            timer       <= '0;
            end_output  <= 1'b0;
            gate_open   <= 1'b0;
            deny_alarm  <= 1'b0;
            fee         <= '0;
            balance_out <= '0;
            for (int i = 0; i < 16; i++) bal_table[i] <= INIT_BALANCE;
        end else begin
            end_output <= 1'b0;
            if (state != 2'b11) armed <= 1'b1;
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        id  <= hipass;
                        fsm <= S_LOOKUP;
                    end
`ifdef TOLL_TOPUP_EN
                    else if (topup_valid && topup_id != 4'd0) begin
                        bal_table[topup_id] <= topup_sum[8] ? 8'hFF : topup_sum[7:0];
                    end
`endif
                end
                S_LOOKUP: begin
                    fee <= class_fee(id[3:2]);
                    bal <= bal_table[id];
                    fsm <= S_CHARGE;
                end
                S_CHARGE: begin
                    // bal == fee is a grant that leaves a zero balance
                    if (id == 4'd0 || bal < fee) begin
                        deny_alarm  <= 1'b1;
                        timer       <= ALARM_LOAD;
                        balance_out <= bal;
                        fsm         <= S_ALARM;
                    end else begin
                        bal_table[id] <= bal - fee;
                        balance_out   <= bal - fee;
                        gate_open     <= 1'b1;
                        timer         <= GATE_LOAD;
                        fsm           <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!car || timer == '0) begin
                        gate_open <= 1'b0;
                        fsm       <= S_DONE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_ALARM: begin
                    if (timer == '0) begin
                        deny_alarm <= 1'b0;
                        fsm        <= S_DONE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_DONE: begin
                    end_output <= 1'b1;
                    armed      <= (state != 2'b11);
                    fsm        <= S_IDLE;
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/toll_output_unit.md
Name: toll_output_unit

Overview:
- Responder to the toll-gate sequencing controller.
- When the controller reaches its OUTPUT state (state == 2'b11), this block:
  - latches the hipass card ID,
  - looks up the fee by vehicle class,
  - debits a per-card balance table,
  - drives the gate or the deny alarm.
- It returns a one-cycle end_output pulse so the controller can go back to waiting for a car.

Parameters:
- FEE_C0, 8'd10: fee for class 0 (hipass[3:2]==0)
- FEE_C1, 8'd20: fee for class 1
- FEE_C2, 8'd35: fee for class 2
- FEE_C3, 8'd50: fee for class 3
- INIT_BALANCE, 8'd100: reset value of every balance entry
- GATE_CYCLES, 16: max cycles the gate is held open
- ALARM_CYCLES, 8: cycles deny_alarm is held

Ports:
- clk, input, 1: clock
- rst, input, 1: synchronous active-high reset
- state, input, 2: controller currentstate (00 init, 01 car, 10 hipass, 11 output)
- car, input, 1: vehicle-present sensor, level
- hipass, input, 4: card ID; [3:2] is class, 0 means no card
- end_output, output, 1: one-cycle done pulse to the controller
- gate_open, output, 1: gate actuator, level
- deny_alarm, output, 1: insufficient funds / invalid card indicator, level
- fee, output, 8: fee of the current transaction, held until next LOOKUP
- balance_out, output, 8: post-transaction balance of the current card
- busy, output, 1: high in every FSM state except IDLE

Behaviour:
- Reset: all outputs 0; FSM to IDLE; all 16 balance entries = INIT_BALANCE; timer = 0. Reset mid-transaction aborts immediately with no debit and no end_output.
- IDLE:
  - if state==11 and armed: latch id=hipass, go to LOOKUP.
  - armed is set when state != 11 has been seen since the last transaction.
  - armed = 1 after reset.
- LOOKUP (1 cycle):
  - fee <= FEE_C[id[3:2]]
  - bal <= table[id]
  - go to CHARGE.
- CHARGE (1 cycle):
  - Deny case, id==0 or bal < fee: deny_alarm<=1, timer<=ALARM_CYCLES-1, balance_out<=bal, go to ALARM. No table write.
  - Grant case, otherwise: table[id] <= bal-fee, balance_out <= bal-fee, gate_open<=1, timer<=GATE_CYCLES-1, go to HOLD.
  - bal==fee is granted, leaving a result of 0.
  - Unsigned 8-bit arithmetic; no underflow is possible because of the compare.
- HOLD:
  - gate_open stays 1.
  - Exit when car==0 or timer==0; otherwise decrement timer.
  - On exit: gate_open<=0, go to DONE.
  - If car is already 0 on the first HOLD cycle, HOLD lasts exactly 1 cycle.
- ALARM:
  - Decrement the timer; at 0, deny_alarm<=0 and go to DONE.
  - Lasts exactly ALARM_CYCLES cycles.
- DONE:
  - end_output=1 for exactly one cycle, armed<=0, go to IDLE.
- Re-arm: the controller leaves 11 about two cycles after the pulse. No retrigger while state still reads 11 after DONE. armed sets on the first cycle with state != 11.
- Latency, grant path: state==11 sampled in IDLE at cycle n; gate_open rises at n+2; end_output at n+3+hold_len.
- state leaves 11 mid-transaction (controller reset): the transaction completes normally and end_output still pulses.
- hipass changing after latch is ignored.

Optional Feature:
- Macro: TOLL_TOPUP_EN
- When defined, adds ports:
  - topup_valid, input, 1
  - topup_id, input, 4
  - topup_amount, input, 8
  - topup_ready, output, 1
- topup_ready = 1 only in IDLE when no transaction is starting that cycle.
- On topup_valid && topup_ready: table[topup_id] <= min(table[topup_id]+topup_amount, 255), saturating. topup_id 0 is ignored.
- Top-up and transaction start in the same cycle: the transaction wins, topup_ready=0 that cycle, and the requester must hold valid.
- When undefined: no extra ports; the table changes only by debit or reset.

Test Plan:
- Reset, then state=11, hipass=4'b0101 (class 1), car=1 for 5 cycles then 0 -> fee=20, balance_out=80, gate_open high from n+2 for 5 cycles, one end_output pulse, table[5]=80.
- Same card charged 5 times at class 1 -> balances 80,60,40,20,0. Sixth attempt -> deny_alarm high 8 cycles, gate_open stays 0, balance_out=0, end_output pulses.
- hipass=0 with state=11 -> deny path, no table write, end_output after ALARM_CYCLES+3 cycles.
- car held 1 indefinitely, hipass=4'b1101 -> fee=50, gate_open exactly 16 cycles (timeout), then end_output.
- state held at 11 for 10 cycles after end_output -> no second transaction. State drops to 01 then back to 11 -> new transaction starts.
- TOLL_TOPUP_EN: topup id 5, amount 200 with table[5]=80 -> 255 (saturated). Topup asserted in the same cycle as a state==11 start -> topup_ready=0, top-up applied after return to IDLE.
